// File: rtl/align_nch_if.sv
// Bus bundle for align_nch: the sample load port and the serialised output stream.
//
// Handshake rules:
//   Load side:   a write is accepted on a rising edge when write = 1 and in_rdy = 1.
//                If write = 1 while in_rdy = 0, the data is dropped and the sticky
//                ovf flag is set.
//   Output side: a word transfers on a rising edge when dv = 1 and o_rdy = 1.
//                While o_rdy = 0, the source holds x_o, dv and last stable.
//                done pulses for one cycle after the word marked last transfers.
interface align_nch_if #(
  parameter int W   = 32,
  parameter int NCH = 2
);
  logic [NCH*W-1:0] x_i;
  logic             write;
  logic             ilv;
  logic             in_rdy;
  logic [W-1:0]     x_o;
  logic             dv;
  logic             o_rdy;
  logic             last;
  logic             done;
  logic             ovf;

  // The aligner itself: it consumes samples and produces the stream.
  modport master (
    input  x_i, write, ilv, o_rdy,
    output in_rdy, x_o, dv, last, done, ovf
  );

  // The surrounding datapath: it feeds samples and sinks the stream.
  modport slave (
    output x_i, write, ilv, o_rdy,
    input  in_rdy, x_o, dv, last, done, ovf
  );
endinterface

// File: rtl/align_nch.sv
// align_nch: loads DEPTH samples from each of NCH channels into a frame buffer,
// then serialises the frame onto one W-bit stream. The order is either
// channel-concatenated or sample-interleaved, chosen by ilv on the frame-completing write.
module align_nch #(
  parameter int W     = 32,
  parameter int NCH   = 2,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  align_nch_if.master bus,
  output logic        dbg_state   // 0 = LOAD, 1 = DRAIN
);
  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [SW-1:0] S_MAX = SW'(DEPTH - 1);
  localparam logic [CW-1:0] C_MAX = CW'(NCH - 1);

  typedef enum logic {LOAD = 1'b0, DRAIN = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   widx_q, widx_d;
  logic [SW-1:0]   s_q, s_d, s_nx;
  logic [CW-1:0]   ch_q, ch_d, ch_nx;
  logic            mode_q, mode_d;
  logic [W-1:0]    x_q, x_d;
  logic            dv_q, dv_d, last_q, last_d, done_q, done_d, ovf_q, ovf_d;
  logic            wr_en;
  logic            at_end;
  logic [W-1:0]    first_word;
  logic [W-1:0]    buf_q [NCH][DEPTH];

  // With a single sample per channel, word 0 is being written on the same edge, so bypass the buffer.
  assign first_word = (DEPTH == 1) ? bus.x_i[W-1:0] : buf_q[0][0];
  // Both orders end on the same buffer cell: the last channel's last sample.
  assign at_end     = (ch_q == C_MAX) && (s_q == S_MAX);

  // Next-state logic, plus the successor of the current drain position for the active order.
  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    ch_d    = ch_q;
    s_d     = s_q;
    mode_d  = mode_q;
    x_d     = x_q;
    dv_d    = dv_q;
    last_d  = last_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    wr_en   = 1'b0;
    ch_nx   = ch_q;
    s_nx    = s_q;
    if (mode_q) begin
      if (ch_q == C_MAX) begin
        ch_nx = '0;
        s_nx  = s_q + 1'b1;
      end else begin
        ch_nx = ch_q + 1'b1;
      end
    end else begin
      if (s_q == S_MAX) begin
        s_nx  = '0;
        ch_nx = ch_q + 1'b1;
      end else begin
        s_nx = s_q + 1'b1;
      end
    end
    unique case (state_q)
      LOAD: begin
        if (bus.write) begin
          wr_en = 1'b1;
          if (widx_q == S_MAX) begin
            widx_d  = '0;
            mode_d  = bus.ilv;
            state_d = DRAIN;
            ch_d    = '0;
            s_d     = '0;
            x_d     = first_word;
            dv_d    = 1'b1;
            last_d  = (NCH == 1) && (DEPTH == 1);
          end else begin
            widx_d = widx_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (bus.write) ovf_d = 1'b1;
        if (dv_q && bus.o_rdy) begin
          if (at_end) begin
            dv_d    = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            state_d = LOAD;
          end else begin
            ch_d   = ch_nx;
            s_d    = s_nx;
            x_d    = buf_q[ch_nx][s_nx];
            last_d = (ch_nx == C_MAX) && (s_nx == S_MAX);
          end
        end
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= LOAD;
      widx_q  <= '0;
      ch_q    <= '0;
      s_q     <= '0;
      mode_q  <= 1'b0;
      x_q     <= '0;
      dv_q    <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      ch_q    <= ch_d;
      s_q     <= s_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      dv_q    <= dv_d;
      last_q  <= last_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  // Frame buffer: all channels are stored at the current write index; contents are not reset.
  always_ff @(posedge clk) begin
    if (rst_n && wr_en) begin
      for (int c = 0; c < NCH; c++) begin
        buf_q[c][widx_q] <= bus.x_i[c*W +: W];
      end
    end
  end

  assign bus.in_rdy = (state_q == LOAD);
  assign bus.x_o    = x_q;
  assign bus.dv     = dv_q;
  assign bus.last   = last_q;
  assign bus.done   = done_q;
  assign bus.ovf    = ovf_q;
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_align_nch.sv
// Testbench for align_nch: a directed vector table, hand sequences for the reset and
// overflow corners, and randomised traffic against a frame-level reference model.
module tb_align_nch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  align_nch_if #(.W(32), .NCH(2)) if0 ();
  align_nch_if #(.W(32), .NCH(3)) if1 ();
  align_nch_if #(.W(32), .NCH(1)) if2 ();
  logic dbg0, dbg1, dbg2;

  align_nch #(.W(32), .NCH(2), .DEPTH(2)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.master), .dbg_state(dbg0));
  align_nch #(.W(32), .NCH(3), .DEPTH(4)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.master), .dbg_state(dbg1));
  align_nch #(.W(32), .NCH(1), .DEPTH(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.master), .dbg_state(dbg2));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model (frame-level rules) ----------------
  int          m_nch, m_depth;
  logic [31:0] m_buf [4][4];
  logic [31:0] exp_q [$];   // words of the frame being drained, in output order
  bit          m_load, m_mode, m_done, m_ovf;
  int          m_wcnt;

  function automatic logic [31:0] word_at(input int k);
    int ch, s;
    if (m_mode) begin
      ch = k % m_nch;
      s  = k / m_nch;
    end else begin
      ch = k / m_depth;
      s  = k % m_depth;
    end
    return m_buf[ch][s];
  endfunction

  task automatic model_reset();
    m_load = 1'b1; m_mode = 1'b0; m_done = 1'b0; m_ovf = 1'b0; m_wcnt = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic wr, input logic [95:0] x, input logic ilv, input logic ordy);
    m_done = 1'b0;
    if (m_load) begin
      if (wr) begin
        for (int c = 0; c < m_nch; c++) m_buf[c][m_wcnt] = x[c*32 +: 32];
        m_wcnt++;
        if (m_wcnt == m_depth) begin
          m_wcnt = 0;
          m_mode = ilv;
          m_load = 1'b0;
          for (int k = 0; k < m_nch * m_depth; k++) exp_q.push_back(word_at(k));
        end
      end
    end else begin
      if (wr) m_ovf = 1'b1;
      if (ordy) begin
        void'(exp_q.pop_front());
        if (exp_q.size() == 0) begin
          m_load = 1'b1;
          m_done = 1'b1;
        end
      end
    end
  endtask

  task automatic cmp(input string tag, input logic in_rdy, input logic dv, input logic [31:0] xo,
                     input logic last, input logic done, input logic ovf);
    chk({tag, "_in_rdy"}, 32'(in_rdy), 32'(m_load));
    chk({tag, "_dv"},     32'(dv),     32'(!m_load));
    chk({tag, "_last"},   32'(last),   32'(!m_load && exp_q.size() == 1));
    chk({tag, "_done"},   32'(done),   32'(m_done));
    chk({tag, "_ovf"},    32'(ovf),    32'(m_ovf));
    if (!m_load) chk({tag, "_x_o"}, xo, exp_q[0]);
  endtask

  task automatic idle_all();
    if0.write = 1'b0; if0.x_i = '0; if0.ilv = 1'b0; if0.o_rdy = 1'b0;
    if1.write = 1'b0; if1.x_i = '0; if1.ilv = 1'b0; if1.o_rdy = 1'b0;
    if2.write = 1'b0; if2.x_i = '0; if2.ilv = 1'b0; if2.o_rdy = 1'b0;
  endtask

  // One clock of stimulus on the chosen instance, followed by a full model comparison.
  task automatic cyc(input int inst, input logic wr, input logic [95:0] x, input logic ilv, input logic ordy);
    @(negedge clk);
    idle_all();
    case (inst)
      0: begin if0.write = wr; if0.x_i = x[63:0]; if0.ilv = ilv; if0.o_rdy = ordy; end
      1: begin if1.write = wr; if1.x_i = x[95:0]; if1.ilv = ilv; if1.o_rdy = ordy; end
      default: begin if2.write = wr; if2.x_i = x[31:0]; if2.ilv = ilv; if2.o_rdy = ordy; end
    endcase
    model_step(wr, x, ilv, ordy);
    @(posedge clk); #1;
    case (inst)
      0: cmp("u0", if0.in_rdy, if0.dv, if0.x_o, if0.last, if0.done, if0.ovf);
      1: cmp("u1", if1.in_rdy, if1.dv, if1.x_o, if1.last, if1.done, if1.ovf);
      default: cmp("u2", if2.in_rdy, if2.dv, if2.x_o, if2.last, if2.done, if2.ovf);
    endcase
  endtask

  task automatic rst(input int inst);
    @(negedge clk);
    idle_all();
    rst_n = 1'b0;
    @(posedge clk); #1;
    model_reset();
    case (inst)
      0: begin cmp("u0_rst", if0.in_rdy, if0.dv, if0.x_o, if0.last, if0.done, if0.ovf); chk("u0_rst_x_o", if0.x_o, 32'h0); end
      1: begin cmp("u1_rst", if1.in_rdy, if1.dv, if1.x_o, if1.last, if1.done, if1.ovf); chk("u1_rst_x_o", if1.x_o, 32'h0); end
      default: begin cmp("u2_rst", if2.in_rdy, if2.dv, if2.x_o, if2.last, if2.done, if2.ovf); chk("u2_rst_x_o", if2.x_o, 32'h0); end
    endcase
    rst_n = 1'b1;
  endtask

  function automatic logic [95:0] rnd96();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  // ---------------- directed vector table (NCH = DEPTH = 2) ----------------
  typedef struct {
    logic        wr;
    logic [63:0] x;
    logic        ilv;
    logic        ordy;
    logic        e_in_rdy, e_dv, e_last, e_done;
    logic [31:0] e_x;
  } vec_t;
  vec_t vecs [14];

  initial begin
    int dcount;
    logic [63:0] a1, a2;
    idle_all();
    a1 = 64'h0000_0010_0000_0001;
    a2 = 64'h0000_0020_0000_0002;
    vecs[0]  = '{1'b1, a1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, a2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1};
    vecs[2]  = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h2};
    vecs[3]  = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10};
    vecs[4]  = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h20};
    vecs[5]  = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, a1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, a2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h1};
    vecs[9]  = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10};
    vecs[10] = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h2};
    vecs[11] = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h20};
    vecs[12] = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
    vecs[13] = '{1'b0, 64'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};

    m_nch = 2; m_depth = 2;
    rst(0);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if0.write = vecs[i].wr; if0.x_i = vecs[i].x; if0.ilv = vecs[i].ilv; if0.o_rdy = vecs[i].ordy;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_in_rdy", i), 32'(if0.in_rdy), 32'(vecs[i].e_in_rdy));
      chk($sformatf("vec%0d_dv", i),     32'(if0.dv),     32'(vecs[i].e_dv));
      chk($sformatf("vec%0d_last", i),   32'(if0.last),   32'(vecs[i].e_last));
      chk($sformatf("vec%0d_done", i),   32'(if0.done),   32'(vecs[i].e_done));
      if (vecs[i].e_dv) chk($sformatf("vec%0d_x_o", i), if0.x_o, vecs[i].e_x);
    end

    // Reset after one of two writes, then a clean frame with no stale word.
    rst(0);
    cyc(0, 1'b1, 96'h0000_00AA_0000_00BB, 1'b0, 1'b1);
    rst(0);
    cyc(0, 1'b1, 96'h0000_0011_0000_0022, 1'b0, 1'b1);
    cyc(0, 1'b1, 96'h0000_0033_0000_0044, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cyc(0, 1'b0, 96'h0, 1'b0, 1'b1);

    // Reset partway through a drain.
    cyc(0, 1'b1, rnd96(), 1'b0, 1'b1);
    cyc(0, 1'b1, rnd96(), 1'b0, 1'b1);
    cyc(0, 1'b0, 96'h0, 1'b0, 1'b1);
    rst(0);
    cyc(0, 1'b1, rnd96(), 1'b1, 1'b1);
    cyc(0, 1'b1, rnd96(), 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cyc(0, 1'b0, 96'h0, 1'b0, 1'b1);

    // Write held high through the whole drain: ovf sets, stays, and the frame is untouched.
    cyc(0, 1'b1, rnd96(), 1'b0, 1'b1);
    cyc(0, 1'b1, rnd96(), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) cyc(0, 1'b1, rnd96(), 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) cyc(0, 1'b0, 96'h0, 1'b0, 1'b1);
    chk("u0_ovf_sticky", 32'(if0.ovf), 32'h1);
    rst(0);

    // Randomised traffic, including writes on the done cycle and overflow attempts.
    for (int i = 0; i < 400; i++)
      cyc(0, $urandom_range(0, 3) != 0, rnd96(), 1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0);

    // NCH = 3, DEPTH = 4 with o_rdy repeating 1,0,0,1.
    m_nch = 3; m_depth = 4;
    rst(1);
    dcount = 0;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 4; i++) cyc(1, 1'b1, rnd96(), f[0], 1'b1);
      for (int i = 0; i < 40; i++) begin
        cyc(1, 1'b0, 96'h0, 1'b0, (i % 4 == 0) || (i % 4 == 3));
        if (if1.done) dcount++;
      end
    end
    chk("u1_done_pulses", 32'(dcount), 32'd2);
    for (int i = 0; i < 300; i++)
      cyc(1, $urandom_range(0, 2) != 0, rnd96(), 1'($urandom_range(0, 1)), $urandom_range(0, 1) != 0);

    // NCH = DEPTH = 1: a single word carrying both dv and last.
    m_nch = 1; m_depth = 1;
    rst(2);
    cyc(2, 1'b1, 96'h8000_0000, 1'b0, 1'b1);
    chk("u2_min_word", if2.x_o, 32'h8000_0000);
    chk("u2_dv_last", {30'h0, if2.dv, if2.last}, 32'h3);
    cyc(2, 1'b0, 96'h0, 1'b0, 1'b1);
    chk("u2_done", 32'(if2.done), 32'h1);
    for (int i = 0; i < 150; i++)
      cyc(2, $urandom_range(0, 1) != 0, rnd96(), 1'($urandom_range(0, 1)), $urandom_range(0, 2) != 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
